// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver. Value updates take effect only at frame
// boundaries. Adds anti-ghosting dead time, leading-zero blanking and pin polarity selection.
module seg7_scan_mux #(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned DIV        = 50000,
   parameter int unsigned DEAD       = 64,
   parameter int unsigned LZB        = 1,
   parameter int unsigned ACTIVE_LOW = 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   output logic [6:0]            seg,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned LAST_CNT = DIV - 1;
   localparam int unsigned LAST_IDX = DIGITS - 1;
   localparam logic        INV      = (ACTIVE_LOW != 0);

   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic [4*DIGITS-1:0]    sh_val;
   logic [4*DIGITS-1:0]    ac_val;
   logic [DIGITS-1:0]      sh_dp;
   logic [DIGITS-1:0]      ac_dp;
   logic                   pending;

   logic [6:0]             seg_q;
   logic                   dp_q;
   logic [DIGITS-1:0]      an_q;
   logic                   frame_q;

   logic                   tick;
   logic                   commit;
   logic                   lit;
   logic [3:0]             nib;
   logic [DIGITS-1:0]      blank;
   logic                   zero_run;
   logic [6:0]             seg_nxt;
   logic [DIGITS-1:0]      an_nxt;

   function automatic logic [6:0] decode(input logic [3:0] h);
      case (h)
         4'h0:    decode = 7'h3F;
         4'h1:    decode = 7'h06;
         4'h2:    decode = 7'h5B;
         4'h3:    decode = 7'h4F;
         4'h4:    decode = 7'h66;
         4'h5:    decode = 7'h6D;
         4'h6:    decode = 7'h7D;
         4'h7:    decode = 7'h07;
         4'h8:    decode = 7'h7F;
         4'h9:    decode = 7'h6F;
         4'hA:    decode = 7'h77;
         4'hB:    decode = 7'h7C;
         4'hC:    decode = 7'h39;
         4'hD:    decode = 7'h5E;
         4'hE:    decode = 7'h79;
         default: decode = 7'h71;
      endcase
   endfunction

   // Scan timing and next output values, all derived from current state
   always_comb begin
      tick     = (cnt == CW'(LAST_CNT));
      commit   = tick && (idx == IW'(LAST_IDX));
      lit      = (DEAD == 0) || (cnt >= CW'(DEAD));
      nib      = ac_val[{idx, 2'b00} +: 4];
      blank    = '0;
      zero_run = 1'b1;
      // A digit is blank only if it and every more-significant digit are zero
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         zero_run = zero_run & (ac_val[4*i +: 4] == 4'h0);
         blank[i] = (LZB != 0) && (i != 0) && zero_run;
      end
      seg_nxt  = blank[idx] ? 7'h00 : decode(nib);
      an_nxt   = lit ? (DIGITS'(1) << idx) : '0;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         cnt     <= '0;
         idx     <= '0;
         sh_val  <= '0;
         sh_dp   <= '0;
         ac_val  <= '0;
         ac_dp   <= '0;
         pending <= 1'b0;
         seg_q   <= '0;
         dp_q    <= 1'b0;
         an_q    <= '0;
         frame_q <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + CW'(1);
         if (tick) begin
            idx <= (idx == IW'(LAST_IDX)) ? '0 : idx + IW'(1);
         end
         if (load) begin
            sh_val  <= value;
            sh_dp   <= dp;
            pending <= 1'b1;
         end
         // Same-cycle load bypasses the shadow so the newest data is committed
         if (commit && (pending || load)) begin
            ac_val  <= load ? value : sh_val;
            ac_dp   <= load ? dp : sh_dp;
            pending <= 1'b0;
         end
         seg_q   <= seg_nxt;
         dp_q    <= ac_dp[idx];
         an_q    <= an_nxt;
         frame_q <= commit;
      end
   end

   assign seg    = seg_q ^ {7{INV}};
   assign dp_out = dp_q ^ INV;
   assign an     = an_q ^ {DIGITS{INV}};
   assign frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: three instances (LZB on, LZB off, active-low pins) share stimulus
// and are checked cycle by cycle against expectations queued as each step is driven.
module tb_seg7_scan_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp;

   logic [6:0]  seg_a, seg_b, seg_c;
   logic        dpo_a, dpo_b, dpo_c;
   logic [3:0]  an_a, an_b, an_c;
   logic        frame_a, frame_b, frame_c;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic [6:0] seg_nz;
      logic       dpv;
      logic       frm;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   seg7_scan_mux #(.DIGITS(4), .DIV(4), .DEAD(1), .LZB(1), .ACTIVE_LOW(0)) dut_a (
      .clk_in(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
      .seg(seg_a), .dp_out(dpo_a), .an(an_a), .frame(frame_a));

   seg7_scan_mux #(.DIGITS(4), .DIV(4), .DEAD(1), .LZB(0), .ACTIVE_LOW(0)) dut_b (
      .clk_in(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
      .seg(seg_b), .dp_out(dpo_b), .an(an_b), .frame(frame_b));

   seg7_scan_mux #(.DIGITS(4), .DIV(4), .DEAD(1), .LZB(1), .ACTIVE_LOW(1)) dut_c (
      .clk_in(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
      .seg(seg_c), .dp_out(dpo_c), .an(an_c), .frame(frame_c));

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string where);
      exp_t e;
      e = q.pop_front();
      cmp({where, " a.an"},    8'(an_a),    8'(e.an));
      cmp({where, " a.seg"},   8'(seg_a),   8'(e.seg));
      cmp({where, " a.dp"},    8'(dpo_a),   8'(e.dpv));
      cmp({where, " a.frame"}, 8'(frame_a), 8'(e.frm));
      cmp({where, " b.an"},    8'(an_b),    8'(e.an));
      cmp({where, " b.seg"},   8'(seg_b),   8'(e.seg_nz));
      cmp({where, " b.dp"},    8'(dpo_b),   8'(e.dpv));
      cmp({where, " b.frame"}, 8'(frame_b), 8'(e.frm));
      cmp({where, " c.an"},    8'(an_c),    8'(e.an ^ 4'hF));
      cmp({where, " c.seg"},   8'(seg_c),   8'(e.seg ^ 7'h7F));
      cmp({where, " c.dp"},    8'(dpo_c),   8'(e.dpv ^ 1'b1));
      cmp({where, " c.frame"}, 8'(frame_c), 8'(e.frm));
   endtask

   // One reset edge, optionally with a competing load
   task automatic reset_step(input string name, input logic with_load);
      exp_t e;
      e = '0;
      q.push_back(e);
      rst_n = 1'b0;
      load  = with_load;
      value = 16'h9999;
      dp    = 4'hF;
      @(posedge clk);
      #1;
      load = 1'b0;
      check_outputs(name);
   endtask

   // Runs ncyc cycles from a frame start; segs packs {d3,d2,d1,d0} 7 bits each
   task automatic run_frame(input string name, input int ncyc,
                            input logic [27:0] segs, input logic [27:0] segs_nz,
                            input logic [3:0] dpm,
                            input int lc0, input logic [15:0] lv0, input logic [3:0] ld0,
                            input int lc1, input logic [15:0] lv1, input logic [3:0] ld1);
      exp_t e;
      int   d;
      int   p;
      for (int c = 0; c < ncyc; c++) begin
         d        = c / 4;
         p        = c % 4;
         e.an     = (p >= 1) ? 4'(1 << d) : 4'h0;
         e.seg    = segs[7*d +: 7];
         e.seg_nz = segs_nz[7*d +: 7];
         e.dpv    = dpm[d];
         e.frm    = (c == 15);
         q.push_back(e);
         load = (c == lc0) || (c == lc1);
         if (c == lc0) begin
            value = lv0;
            dp    = ld0;
         end
         if (c == lc1) begin
            value = lv1;
            dp    = ld1;
         end
         @(posedge clk);
         #1;
         load = 1'b0;
         check_outputs($sformatf("%s c%0d", name, c));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      load  = 1'b0;
      value = 16'h0;
      dp    = 4'h0;

      for (int i = 0; i < 3; i++) reset_step($sformatf("reset%0d", i), 1'b0);
      rst_n = 1'b1;

      // Zero display after reset; load 1234 for the next frame
      run_frame("f0_zero", 16, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000,
                0, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
      run_frame("f1_scan", 16, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      // Two mid-frame loads: frame keeps old value, only the last load is committed
      run_frame("f2_tear", 16, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100,
                5, 16'hAAAA, 4'b0000, 9, 16'h5555, 4'b0000);
      // Load in the commit cycle itself
      run_frame("f3_5555", 16, {7'h6D, 7'h6D, 7'h6D, 7'h6D}, {7'h6D, 7'h6D, 7'h6D, 7'h6D}, 4'b0000,
                15, 16'hBEEF, 4'b0000, -1, 16'h0, 4'h0);
      run_frame("f4_beef", 16, {7'h7C, 7'h79, 7'h79, 7'h71}, {7'h7C, 7'h79, 7'h79, 7'h71}, 4'b0000,
                0, 16'h0030, 4'b0000, -1, 16'h0, 4'h0);
      run_frame("f5_lzb", 16, {7'h00, 7'h00, 7'h4F, 7'h3F}, {7'h3F, 7'h3F, 7'h4F, 7'h3F}, 4'b0000,
                0, 16'h0008, 4'b0000, -1, 16'h0, 4'h0);
      run_frame("f6_eight", 16, {7'h00, 7'h00, 7'h00, 7'h7F}, {7'h3F, 7'h3F, 7'h3F, 7'h7F}, 4'b0000,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      // Partial frame with a pending load, then reset mid-slot with a competing load
      run_frame("f7_part", 7, {7'h00, 7'h00, 7'h00, 7'h7F}, {7'h3F, 7'h3F, 7'h3F, 7'h7F}, 4'b0000,
                2, 16'h9999, 4'b1111, -1, 16'h0, 4'h0);
      reset_step("midreset", 1'b1);
      rst_n = 1'b1;
      run_frame("f8_post", 16, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame("f9_post", 16, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
